mem_rw_arbiter: RTL
===================

Name: mem_rw_arbiter

Overview:
- Shares the single read/write port of main_mem between several requesters: core, front-panel load/look, and halt/inwait readback.
- Replaces the ad-hoc combinational mux at system level.
- Each requester gets a val/rdy request channel and a one-cycle-latency read-response strobe.
- Policy is either fixed priority or round-robin, with starvation promotion.
- Per-requester enables let the system FSM gate requesters.

Parameters:
- NREQ, 3, number of requesters; index 0 is highest fixed priority.
- AW, 8, address width.
- DW, 16, data width.
- ARB_MODE, 0, 0 = fixed priority, 1 = round-robin.
- STARVE_LIMIT, 7, number of denied cycles before a requester is promoted; 0 disables promotion.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_en_i  in  NREQ  per-requester enable mask from the system FSM.
- req_val_i  in  NREQ  request valid.
- req_wen_i  in  NREQ  1 = write, 0 = read.
- req_addr_i  in  NREQ x AW  request address.
- req_wdata_i  in  NREQ x DW  write data.
- req_rdy_o  out  NREQ  request accepted this cycle.
- rsp_val_o  out  NREQ  read data valid for this requester.
- rsp_rdata_o  out  DW  read data, shared by all requesters.
- mem_val_o  out  1  downstream valid.
- mem_wen_o  out  1  downstream write enable.
- mem_addr_o  out  AW  downstream address.
- mem_wdata_o  out  DW  downstream write data.
- mem_rdy_i  in  1  downstream ready.
- mem_rdata_i  in  DW  downstream read data, valid the cycle after acceptance.
- grant_o  out  $clog2(NREQ)  current grantee, debug only.
- busy_o  out  1  high when mem_val_o is high or a read response is pending.

Behaviour:
- Reset (async, rst_ni low): all outputs 0, rr pointer 0, lock cleared, wait counters 0, response owner invalid.
- Eligible set: elig = req_val_i & req_en_i. mem_val_o = |elig.
- Grant is computed combinationally each cycle, in this order:
  - Lock: the previous cycle had mem_val_o=1, mem_rdy_i=0 and grantee g, and elig[g] is still 1 → grant g. The downstream command therefore stays stable until accepted.
  - Promotion: any eligible requester with wait_cnt >= STARVE_LIMIT (and STARVE_LIMIT != 0) → grant the lowest index among the starved.
  - Otherwise ARB_MODE 0 picks the lowest eligible index. ARB_MODE 1 picks the first eligible index at or after rr_ptr, wrapping modulo NREQ.
- Downstream mux: mem_wen_o, mem_addr_o and mem_wdata_o come from the grantee. When mem_val_o=0 they are 0.
- Ready routing: req_rdy_o[grant] = mem_rdy_i & mem_val_o; all other req_rdy_o bits are 0.
- Acceptance = mem_val_o & mem_rdy_i. On acceptance:
  - rr_ptr <= (grant+1) mod NREQ.
  - Lock clears.
  - If the request was a read, owner <= grant and pend <= 1; otherwise pend <= 0.
  - Without an acceptance, pend <= 0.
- Response: rsp_val_o[owner] = pend. rsp_rdata_o = mem_rdata_i when pend=1, else 0. Writes produce no response.
- Back-to-back reads are allowed: a new acceptance can occur in the same cycle that the previous response is presented.
- Wait counters, one per requester, saturating at STARVE_LIMIT:
  - increment when elig[i] is 1 and requester i is not accepted;
  - clear when requester i is accepted, or when elig[i] is 0.
- Lock break: if the locked requester drops val or loses its enable (e.g. core reset mid-request), the lock releases in that same cycle. The arbiter may then present a different requester; main_mem tolerates val retraction.
- Enable drop while a read response is pending: the response is still delivered to the owner.
- No requests: mem_val_o=0, grant_o holds 0, and no state changes except pend clearing.

Decomposition:
- Package mem_arb_pkg holds ARB_FIXED=0, ARB_RR=1, and a grant index typedef sized by NREQ.
- One sub-module, arb_pick: a rotating-base priority picker with inputs req vector and base index, and outputs one-hot grant and index.
  - It is instantiated twice: once for the starved set with base 0, and once for the normal set with base 0 or rr_ptr.
  - The lock override is applied in mem_rw_arbiter.

Test Plan:
- Fixed mode: elig = 3'b111, reads to addrs 0x10/0x20/0x30, mem_rdy_i=1 → grant order 0,0,… (requester 0 holds the port while its val stays high). Requester 1 is granted on the STARVE_LIMIT-th denied cycle (cycle 7); rsp_val_o[1] fires one cycle later with the mem_rdata_i value.
- RR mode: all three requesters continuously requesting, mem_rdy_i=1 → grants cycle 0,1,2,0,1,2; each read response arrives at its owner the next cycle.
- Lock: requester 2 writes 0xBEEF to 0x44, mem_rdy_i=0 for 4 cycles while requester 0 also requests → mem_addr_o stays 0x44 and mem_wdata_o stays 0xBEEF until mem_rdy_i=1. No rsp_val_o is asserted.
- Lock break: requester 0 locked with rdy low, then req_en_i[0] drops → requester 1 is granted the same cycle, and the wait counter for requester 0 clears.
- Back-to-back: requester 1 issues reads to 0x01 then 0x02 on consecutive cycles, memory returns 0x1111 then 0x2222 → rsp_val_o[1] is high two cycles with those data values.
- Async reset mid-read (pend=1) → all outputs go to 0 immediately, and no response is delivered after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the main_mem read/write arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int ARB_NREQ  = 3;
    typedef logic [$clog2(ARB_NREQ)-1:0] gnt_idx_t;

endpackage

// File: rtl/arb_pick.sv
// Rotating-base priority picker: first set request at or after base_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the pick with its own ready.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] base_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o
);

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(base_i) + k) % N;
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_rw_arbiter.sv
// Shares the main_mem port between requesters (fixed or round-robin, starvation promotion).
// Latency: command path combinational; read response one cycle after acceptance.
// Backpressure: mem_rdy_i routed to the grantee only; a stalled grantee keeps the port locked.
module mem_rw_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int AW           = 8,
    parameter int DW           = 16,
    parameter int ARB_MODE     = ARB_FIXED,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_en_i,
    input  logic [NREQ-1:0]          req_val_i,
    input  logic [NREQ-1:0]          req_wen_i,
    input  logic [NREQ-1:0][AW-1:0]  req_addr_i,
    input  logic [NREQ-1:0][DW-1:0]  req_wdata_i,
    output logic [NREQ-1:0]          req_rdy_o,
    output logic [NREQ-1:0]          rsp_val_o,
    output logic [DW-1:0]            rsp_rdata_o,
    output logic                     mem_val_o,
    output logic                     mem_wen_o,
    output logic [AW-1:0]            mem_addr_o,
    output logic [DW-1:0]            mem_wdata_o,
    input  logic                     mem_rdy_i,
    input  logic [DW-1:0]            mem_rdata_i,
    output logic [$clog2(NREQ)-1:0]  grant_o,
    output logic                     busy_o
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [NREQ-1:0] elig, starved, s_oh, n_oh;
    logic [GW-1:0]   s_idx, n_idx, grant, rr_base;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d, lock_gnt_q, owner_q, owner_d;
    logic            lock_q, lock_d, pend_q, pend_d;
    logic            mem_val, acc, rd_acc;
    logic [CW-1:0]   wait_q [NREQ];
    logic [CW-1:0]   wait_d [NREQ];

    // Gating with reset keeps every output low while reset is held.
    assign elig    = rst_ni ? (req_val_i & req_en_i) : '0;
    assign mem_val = |elig;
    assign acc     = mem_val & mem_rdy_i;
    assign rd_acc  = acc & ~mem_wen_o;
    assign rr_base = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NREQ; i++) begin
            starved[i] = elig[i] && (STARVE_LIMIT != 0) && (int'(wait_q[i]) >= STARVE_LIMIT);
        end
    end

    arb_pick #(.N(NREQ), .IW(GW)) u_pick_starve (
        .req_i     (starved),
        .base_i    ('0),
        .gnt_oh_o  (s_oh),
        .gnt_idx_o (s_idx)
    );

    arb_pick #(.N(NREQ), .IW(GW)) u_pick_norm (
        .req_i     (elig),
        .base_i    (rr_base),
        .gnt_oh_o  (n_oh),
        .gnt_idx_o (n_idx)
    );

    // A stalled command stays put until accepted or its requester withdraws.
    always_comb begin
        grant = '0;
        if (lock_q && elig[lock_gnt_q]) begin
            grant = lock_gnt_q;
        end else if (|s_oh) begin
            grant = s_idx;
        end else if (|n_oh) begin
            grant = n_idx;
        end
    end

    always_comb begin
        mem_wen_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        req_rdy_o   = '0;
        if (mem_val) begin
            mem_wen_o        = req_wen_i[grant];
            mem_addr_o       = req_addr_i[grant];
            mem_wdata_o      = req_wdata_i[grant];
            req_rdy_o[grant] = mem_rdy_i;
        end
    end

    always_comb begin
        rsp_val_o = '0;
        if (pend_q) begin
            rsp_val_o[owner_q] = 1'b1;
        end
    end

    assign rsp_rdata_o = pend_q ? mem_rdata_i : '0;
    assign mem_val_o   = mem_val;
    assign grant_o     = grant;
    assign busy_o      = mem_val | pend_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (acc) begin
            rr_ptr_d = (grant == GW'(NREQ - 1)) ? '0 : grant + GW'(1);
        end
        lock_d  = mem_val & ~mem_rdy_i;
        pend_d  = rd_acc;
        owner_d = rd_acc ? grant : owner_q;
        for (int i = 0; i < NREQ; i++) begin
            wait_d[i] = '0;
            if (elig[i] && !(acc && int'(grant) == i)) begin
                wait_d[i] = (int'(wait_q[i]) < STARVE_LIMIT) ? wait_q[i] + CW'(1) : wait_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_gnt_q <= '0;
            pend_q     <= 1'b0;
            owner_q    <= '0;
            for (int i = 0; i < NREQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_gnt_q <= grant;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            for (int i = 0; i < NREQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

endmodule
